// File: rtl/peripheral_spi_master_ms.sv
// peripheral_spi_master_ms: SPI master on the j1 I/O bus (cs/addr/rd/wr).
// Configurable word width, all four SPI modes, fixed SCK divider, NUM_SS
// active-low selects, TX FIFO with optional SS-hold bursts and overrun flag.
// Optional feature macro: SPI_MS_IRQ_EN adds the irq output and ctrl[9] irq_en.
module peripheral_spi_master_ms #(
  parameter int DATA_W    = 8,
  parameter int NUM_SS    = 4,
  parameter int CLK_DIV   = 4,
  parameter int TXF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       d_in,
  input  logic              cs,
  input  logic [3:0]        addr,
  input  logic              rd,
  input  logic              wr,
  output logic [15:0]       d_out,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_SS-1:0] ss
`ifdef SPI_MS_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PW = (TXF_DEPTH > 1) ? $clog2(TXF_DEPTH) : 1;
  localparam int LW = PW + 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * DATA_W);

`ifdef SPI_MS_IRQ_EN
  localparam logic [15:0] CTRL_MASK = 16'h03F3;
`else
  localparam logic [15:0] CTRL_MASK = 16'h01F3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  // Active-low select for the chosen index; out-of-range index selects nobody.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [3:0] idx);
    logic [NUM_SS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(idx) == i) r[i] = 1'b0;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]       half_q, half_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic [NUM_SS-1:0]   ss_q, ss_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                avail_q, avail_d;
  logic                ovr_q, ovr_d;
  logic [15:0]         ctrl_q, ctrl_d;
  logic [15:0]         d_out_q, d_out_d;
  logic [LW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   fifo_mem [TXF_DEPTH];

  logic                pop, done;
  logic                push_req, push_ok, drop;
  logic                ctrl_wr, rd_rx, rd_st;
  logic [LW-1:0]       level;
  logic                fifo_empty, fifo_full, busy;
  logic [DATA_W-1:0]   fifo_head;
  logic                cnt_last, half_last;
  logic [15:0]         status;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(TXF_DEPTH));
  assign fifo_head  = fifo_mem[rd_ptr_q[PW-1:0]];
  assign busy       = (state_q != S_IDLE);
  assign cnt_last   = (cnt_q == CW'(CLK_DIV - 1));
  assign half_last  = (half_q == HW'(2 * DATA_W - 1));

  assign push_req = cs & wr & (addr == 4'h0);
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign push_ok  = push_req & (~fifo_full | pop);
  assign drop     = push_req & ~push_ok;
  assign ctrl_wr  = cs & wr & (addr == 4'h2) & ~busy;
  assign rd_rx    = cs & rd & (addr == 4'h4);
  assign rd_st    = cs & rd & (addr == 4'h6);

  assign d_out = d_out_q;
  assign mosi  = mosi_q;
  assign sck   = sck_q;
  assign ss    = ss_q;

  // Control register and bus-side flags; completion beats a same-cycle clear.
  always_comb begin
    ctrl_d    = ctrl_wr ? (d_in & CTRL_MASK) : ctrl_q;
    wr_ptr_d  = wr_ptr_q + LW'(push_ok);
    rd_ptr_d  = rd_ptr_q + LW'(pop);
    rx_data_d = rx_data_q;
    avail_d   = avail_q;
    ovr_d     = ovr_q;
    if (rd_rx) avail_d = 1'b0;
    if (rd_st) ovr_d = 1'b0;
    if (drop)  ovr_d = 1'b1;
    if (done) begin
      rx_data_d = rx_sr_q;
      avail_d   = 1'b1;
      if (avail_q && !rd_rx) ovr_d = 1'b1;
    end
  end

  // Read mux; tx_level keeps its low four bits (tx_full covers a full 16-deep FIFO).
  always_comb begin
    status      = '0;
    status[0]   = busy;
    status[1]   = avail_q;
    status[2]   = fifo_full;
    status[3]   = fifo_empty;
    status[4]   = ovr_q;
    status[11:8] = 4'(level);
    d_out_d = '0;
    if (cs && rd) begin
      case (addr)
        4'h4:    d_out_d = 16'(rx_data_q);
        4'h6:    d_out_d = status;
        4'h8:    d_out_d = ctrl_q;
        default: d_out_d = '0;
      endcase
    end
  end

  // Transfer sequencer: SETUP, 2*DATA_W half-periods of XFER, HOLD, then burst or idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Idle uses the incoming ctrl value so a CPOL write shows on sck at once.
        sck_d = ctrl_d[1];
        ss_d  = '1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          cnt_d   = '0;
          ss_d    = ss_decode(ctrl_d[7:4]);
          tx_sr_d = fifo_head;
          if (!ctrl_d[0]) mosi_d = fifo_head[DATA_W-1];
        end
      end
      S_SETUP: begin
        sck_d = ctrl_q[1];
        if (cnt_last) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (cnt_last) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          // Even half-periods end on a leading edge, odd ones on a trailing edge.
          if (!half_q[0]) begin
            if (ctrl_q[0]) begin
              mosi_d  = tx_sr_q[DATA_W-1];
              tx_sr_d = tx_sr_q << 1;
            end else begin
              rx_sr_d = (rx_sr_q << 1) | DATA_W'(miso);
            end
          end else begin
            if (ctrl_q[0]) begin
              rx_sr_d = (rx_sr_q << 1) | DATA_W'(miso);
            end else begin
              tx_sr_d = tx_sr_q << 1;
              mosi_d  = tx_sr_d[DATA_W-1];
            end
          end
          if (half_last) begin
            half_d  = '0;
            state_d = S_HOLD;
          end else begin
            half_d = half_q + HW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        sck_d = ctrl_q[1];
        if (cnt_last) begin
          cnt_d = '0;
          done  = 1'b1;
          if (!fifo_empty && ctrl_q[8]) begin
            // Burst continuation: the first half-period of XFER is the setup time.
            pop     = 1'b1;
            state_d = S_XFER;
            half_d  = '0;
            tx_sr_d = fifo_head;
            if (!ctrl_q[0]) mosi_d = fifo_head[DATA_W-1];
          end else begin
            state_d = S_IDLE;
            ss_d    = '1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= '1;
      rx_data_q <= '0;
      avail_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ctrl_q    <= '0;
      d_out_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      rx_data_q <= rx_data_d;
      avail_q   <= avail_d;
      ovr_q     <= ovr_d;
      ctrl_q    <= ctrl_d;
      d_out_q   <= d_out_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Shift registers are pure datapath; each word fully reloads/refills them.
  always_ff @(posedge clk) begin
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
  end

  // TX FIFO storage; pointer reset alone empties it.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[PW-1:0]] <= d_in[DATA_W-1:0];
  end

`ifdef SPI_MS_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = ctrl_q[9] & (avail_q | ovr_q | (fifo_empty & ~busy));
  assign irq   = irq_q;

  // Registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end
`endif

endmodule

// File: tb/tb_peripheral_spi_master_ms.sv
// Testbench for peripheral_spi_master_ms: default instance plus a 12-bit,
// CLK_DIV=1 instance. Slave model, edge monitor and an rx scoreboard.
module tb_peripheral_spi_master_ms;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [3:0]  addr;
  logic [15:0] d_out;
  logic        miso, mosi, sck;
  logic [3:0]  ss;

  logic [15:0] d_in12;
  logic        cs12, rd12, wr12;
  logic [3:0]  addr12;
  logic [15:0] d_out12;
  logic        mosi12, sck12;
  logic [3:0]  ss12;
`ifdef SPI_MS_IRQ_EN
  logic        irq, irq12;
`endif

  always #5 clk = ~clk;

  peripheral_spi_master_ms u_dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .miso(miso), .mosi(mosi), .sck(sck), .ss(ss)
`ifdef SPI_MS_IRQ_EN
    , .irq(irq)
`endif
  );

  peripheral_spi_master_ms #(.DATA_W(12), .NUM_SS(4), .CLK_DIV(1), .TXF_DEPTH(4)) u_dut12 (
    .clk(clk), .rst(rst), .d_in(d_in12), .cs(cs12), .addr(addr12), .rd(rd12), .wr(wr12),
    .d_out(d_out12), .miso(mosi12), .mosi(mosi12), .sck(sck12), .ss(ss12)
`ifdef SPI_MS_IRQ_EN
    , .irq(irq12)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  // Slave model and wire monitor
  logic        lb = 1'b1;
  logic        cur_cpol = 1'b0;
  logic [7:0]  slave_tx = 8'h00;
  logic        slave_bit;
  int          sidx = 0;
  int          pulses = 0;
  logic [15:0] mosi_cap = '0;
  logic        sck_prev = 1'b0;
  logic [3:0]  ss_prev = 4'hF;
  int          ss_low[4] = '{0, 0, 0, 0};
  int          ss_rise[4] = '{0, 0, 0, 0};
  int          pulses12 = 0;
  logic [15:0] cap12 = '0;
  logic        sck12_prev = 1'b0;
  int          ss12_low = 0;

  always_comb slave_bit = (sidx < 8) ? slave_tx[7 - sidx] : 1'b0;
  assign miso = lb ? mosi : slave_bit;

  always @(negedge clk) begin
    if (sck !== sck_prev && sck !== cur_cpol) begin
      pulses++;
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    if (sck !== sck_prev && sck === cur_cpol && ss != 4'hF) sidx++;
    if (ss == 4'hF) sidx = 0;
    for (int i = 0; i < 4; i++) begin
      if (!ss[i]) ss_low[i]++;
      if (ss[i] && !ss_prev[i]) ss_rise[i]++;
    end
    sck_prev = sck;
    ss_prev = ss;
    if (sck12 && !sck12_prev) begin
      pulses12++;
      cap12 = {cap12[14:0], mosi12};
    end
    if (!ss12[0]) ss12_low++;
    sck12_prev = sck12;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); cs = 1'b0; rd = 1'b0; d = d_out;
  endtask

  task automatic sb_rx(input string nm);
    logic [15:0] v, e;
    bus_rd(4'h4, v);
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got 0x%0h, expected entry missing from scoreboard", nm, v);
    end else begin
      e = exp_q.pop_front();
      check(nm, v, e);
    end
  endtask

  typedef struct {
    logic [15:0] ctrl;
    logic [15:0] data;
    logic        cpol;
    logic [15:0] exp_rx;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic [15:0] v;
    int p0, l0, r0, l1, l2, l3;

    vecs[0] = '{16'h0000, 16'h0081, 1'b0, 16'h0081};
    vecs[1] = '{16'h0001, 16'h0081, 1'b0, 16'h0081};
    vecs[2] = '{16'h0002, 16'h0081, 1'b1, 16'h0081};
    vecs[3] = '{16'h0003, 16'h0081, 1'b1, 16'h0081};
    vecs[4] = '{16'h0012, 16'h005A, 1'b1, 16'h005A};
    vecs[5] = '{16'h0031, 16'h00C3, 1'b0, 16'h00C3};

    rst = 1'b1; d_in = '0; cs = 0; rd = 0; wr = 0; addr = '0;
    d_in12 = '0; cs12 = 0; rd12 = 0; wr12 = 0; addr12 = '0;
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 4'hF);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_dout", d_out, 16'h0000);
    rst = 1'b0;
    bus_rd(4'h6, v); check("rst_status", v, 16'h0008);

    // ctrl write mask, unmapped accesses
    cur_cpol = 1'b1;
    bus_wr(4'h2, 16'hFFFF);
    bus_rd(4'h8, v);
`ifdef SPI_MS_IRQ_EN
    check("ctrl_mask", v, 16'h03F3);
`else
    check("ctrl_mask", v, 16'h01F3);
`endif
    check("ctrl_cpol_idle", sck, 1'b1);
    bus_wr(4'hA, 16'h1234);
    bus_rd(4'hC, v); check("unmapped_rd", v, 16'h0000);
    cur_cpol = 1'b0;
    bus_wr(4'h2, 16'h0000);
    check("ctrl_cpol0_idle", sck, 1'b0);

    // Mode 0, ss_idx=1, slave answers 0x3C
    lb = 1'b0; slave_tx = 8'h3C;
    bus_wr(4'h2, 16'h0010);
    p0 = pulses; l0 = ss_low[0]; l1 = ss_low[1]; l2 = ss_low[2]; l3 = ss_low[3];
    bus_wr(4'h0, 16'h00A5);
    exp_q.push_back(16'h003C);
    repeat (80) @(negedge clk);
    check("m0_ss1_low", ss_low[1] - l1, 72);
    check("m0_others_low", (ss_low[0] - l0) + (ss_low[2] - l2) + (ss_low[3] - l3), 0);
    check("m0_pulses", pulses - p0, 8);
    check("m0_mosi", mosi_cap[7:0], 8'hA5);
    bus_rd(4'h6, v); check("m0_status", v, 16'h000A);
    sb_rx("m0_rx");
    @(negedge clk); check("m0_dout_clear", d_out, 16'h0000);
    bus_rd(4'h6, v); check("m0_status_after", v, 16'h0008);
    lb = 1'b1;

    // Mode table with loopback
    for (int i = 0; i < 6; i++) begin
      cur_cpol = vecs[i].cpol;
      bus_wr(4'h2, vecs[i].ctrl);
      check($sformatf("tab%0d_sck_idle", i), sck, vecs[i].cpol);
      p0 = pulses;
      bus_wr(4'h0, vecs[i].data);
      exp_q.push_back(vecs[i].exp_rx);
      repeat (80) @(negedge clk);
      check($sformatf("tab%0d_pulses", i), pulses - p0, 8);
      check($sformatf("tab%0d_mosi", i), mosi_cap[7:0], vecs[i].data[7:0]);
      check($sformatf("tab%0d_sck_end", i), sck, vecs[i].cpol);
      sb_rx($sformatf("tab%0d_rx", i));
    end
    cur_cpol = 1'b0;

    // Burst with ss_hold on ss[2]: one continuous select, 24 pulses
    bus_wr(4'h2, 16'h0120);
    p0 = pulses; l2 = ss_low[2]; r0 = ss_rise[2];
    bus_wr(4'h0, 16'h0011);
    bus_wr(4'h0, 16'h0022);
    bus_wr(4'h0, 16'h0033);
    exp_q.push_back(16'h0033);
    repeat (230) @(negedge clk);
    check("hold_pulses", pulses - p0, 24);
    check("hold_ss_low", ss_low[2] - l2, 208);
    check("hold_ss_rise", ss_rise[2] - r0, 1);
    bus_rd(4'h6, v); check("hold_status_ovr", v, 16'h001A);
    sb_rx("hold_rx_last");
    bus_rd(4'h6, v); check("hold_status_clr", v, 16'h0008);

    // Same without ss_hold: select released between words
    bus_wr(4'h2, 16'h0020);
    l2 = ss_low[2]; r0 = ss_rise[2];
    bus_wr(4'h0, 16'h0011);
    bus_wr(4'h0, 16'h0022);
    exp_q.push_back(16'h0022);
    repeat (160) @(negedge clk);
    check("nohold_ss_rise", ss_rise[2] - r0, 2);
    check("nohold_ss_low", ss_low[2] - l2, 144);
    bus_rd(4'h6, v); check("nohold_status", v, 16'h001A);
    sb_rx("nohold_rx");
    bus_rd(4'h6, v); check("nohold_status_clr", v, 16'h0008);

    // FIFO full, dropped push, ctrl write while busy
    bus_wr(4'h2, 16'h0100);
    for (int i = 1; i <= 5; i++) bus_wr(4'h0, 16'h0090 + 16'(i));
    exp_q.push_back(16'h0095);
    bus_rd(4'h6, v); check("full_status", v, 16'h0405);
    bus_wr(4'h0, 16'h00EE);
    bus_rd(4'h6, v); check("full_drop_ovr", v, 16'h0415);
    bus_rd(4'h6, v); check("full_ovr_cleared", v, 16'h0405);
    bus_wr(4'h2, 16'h0003);
    bus_rd(4'h8, v); check("ctrl_busy_ignored", v, 16'h0100);
    repeat (340) @(negedge clk);
    bus_rd(4'h6, v); check("full_end_status", v, 16'h001A);
    sb_rx("full_rx_last");
    bus_rd(4'h6, v); check("full_end_status_clr", v, 16'h0008);

    // ss_idx beyond NUM_SS: transfer runs, no select asserted
    bus_wr(4'h2, 16'h0050);
    p0 = pulses; l0 = ss_low[0]; l1 = ss_low[1]; l2 = ss_low[2]; l3 = ss_low[3];
    bus_wr(4'h0, 16'h003C);
    exp_q.push_back(16'h003C);
    repeat (80) @(negedge clk);
    check("oob_no_ss", (ss_low[0] - l0) + (ss_low[1] - l1) + (ss_low[2] - l2) + (ss_low[3] - l3), 0);
    check("oob_pulses", pulses - p0, 8);

    // rx read in the completion cycle: old data returned, new data kept, no ovr
    bus_wr(4'h0, 16'h0066);
    exp_q.push_back(16'h0066);
    repeat (71) @(negedge clk);
    sb_rx("simul_rx_old");
    bus_rd(4'h6, v); check("simul_status", v, 16'h000A);
    sb_rx("simul_rx_new");

    // Reset in the middle of a transfer
    bus_wr(4'h2, 16'h0002);
    bus_wr(4'h0, 16'h0077);
    bus_wr(4'h0, 16'h0078);
    repeat (25) @(negedge clk);
    cur_cpol = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ss", ss, 4'hF);
    check("midrst_sck", sck, 1'b0);
    rst = 1'b0;
    bus_rd(4'h6, v); check("midrst_status", v, 16'h0008);
    bus_rd(4'h4, v); check("midrst_rx", v, 16'h0000);
    bus_rd(4'h8, v); check("midrst_ctrl", v, 16'h0000);

    // 12-bit word, CLK_DIV=1, loopback
    l0 = ss12_low; p0 = pulses12;
    @(negedge clk); cs12 = 1'b1; wr12 = 1'b1; addr12 = 4'h0; d_in12 = 16'h0ABC;
    @(negedge clk); cs12 = 1'b0; wr12 = 1'b0;
    repeat (40) @(negedge clk);
    check("w12_busy_clks", ss12_low - l0, 26);
    check("w12_pulses", pulses12 - p0, 12);
    check("w12_mosi", cap12[11:0], 12'hABC);
    @(negedge clk); cs12 = 1'b1; rd12 = 1'b1; addr12 = 4'h4;
    @(negedge clk); cs12 = 1'b0; rd12 = 1'b0;
    check("w12_rx", d_out12, 16'h0ABC);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
